// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WAIT stage sequencer with halt, memory timeout and sticky abort flag.
// Define STAGE_PERF_CNT_EN to build the cycle/instruction performance counters.
module stage_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_inst,
    input  logic             mem_force,
    input  logic             mem_store,
    input  logic             dmem_ack,
    input  logic             halt,
    output logic             IR_Wen,
    output logic             PC_Wen,
    output logic             PSR_Wen,
    output logic             RF_Wen,
    output logic             ST_Wen,
    output logic             EXSTtoMEM_Wen,
    output logic             dmem_req,
    output logic             busy,
    output logic             timeout_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TO_C = WCNT_W'(TIMEOUT);
    localparam logic MEM_IMM = (MEM_WAIT == 0);

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              terr_q, terr_d;
    logic              wait_ok_c, done_c, abort_c;

    // Minimum-wait qualifier; a zero MEM_WAIT accepts any counter value.
    generate
        if (MEM_WAIT == 0) begin : g_nowait
            assign wait_ok_c = 1'b1;
        end else begin : g_wait
            localparam logic [WCNT_W-1:0] MW_C = WCNT_W'(MEM_WAIT);
            assign wait_ok_c = (wait_q >= MW_C);
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        terr_d        = terr_q;
        IR_Wen        = 1'b0;
        PC_Wen        = 1'b0;
        PSR_Wen       = 1'b0;
        RF_Wen        = 1'b0;
        ST_Wen        = 1'b0;
        EXSTtoMEM_Wen = 1'b0;
        dmem_req      = 1'b0;
        done_c        = 1'b0;
        abort_c       = 1'b0;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
                if (halt) begin
                    state_d = S_HALT;
                end else begin
                    IR_Wen  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                PSR_Wen       = 1'b1;
                ST_Wen        = 1'b1;
                EXSTtoMEM_Wen = 1'b1;
                if (mem_inst) begin
                    state_d = S_MEM;
                end else begin
                    RF_Wen  = 1'b1;
                    PC_Wen  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                wait_d   = '0;
                done_c   = MEM_IMM & dmem_ack;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                done_c   = wait_ok_c & dmem_ack;
                abort_c  = !done_c && (wait_q == TO_C);
                if (!done_c && !abort_c) begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            S_HALT: begin
                if (!halt) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        // Completion: a forced stack access restarts MEM instead of retiring.
        if (done_c) begin
            RF_Wen = ~mem_store;
            if (mem_force) begin
                ST_Wen        = 1'b1;
                EXSTtoMEM_Wen = 1'b1;
                state_d       = S_MEM;
            end else begin
                PC_Wen  = 1'b1;
                state_d = S_FETCH;
            end
        end
        if (abort_c) begin
            PC_Wen  = 1'b1;
            terr_d  = 1'b1;
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_RST;
            wait_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            terr_q  <= terr_d;
        end
    end

    assign state       = state_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                         (state_q == S_MEM)   || (state_q == S_WAIT);

`ifdef STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;

    always_comb begin
        cyc_d  = cyc_q;
        inst_d = inst_q;
        if (state_q != S_RST) begin
            cyc_d = cyc_q + CNT_W'(1);
        end
        if (PC_Wen) begin
            inst_d = inst_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            inst_q <= inst_d;
        end
    end

    assign cyc_cnt  = cyc_q;
    assign inst_cnt = inst_q;
`else
    assign cyc_cnt  = '0;
    assign inst_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: two parameterisations driven by per-instruction timelines
// derived from the sequencing rules (ack delay, minimum wait, timeout, halt, reset).
module tb_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn0, rn1;
    logic mem_inst, mem_force, mem_store, dmem_ack, halt;

    logic a_ir, a_pc, a_psr, a_rf, a_st, a_ex, a_req, a_busy, a_terr;
    logic [2:0]  a_state;
    logic [31:0] a_cyc, a_inst;
    logic b_ir, b_pc, b_psr, b_rf, b_st, b_ex, b_req, b_busy, b_terr;
    logic [2:0]  b_state;
    logic [7:0]  b_cyc, b_inst;

    stage_sequencer #(.MEM_WAIT(0), .TIMEOUT(255), .CNT_W(32)) u_dut0 (
        .clk(clk), .resetn(rn0), .mem_inst(mem_inst), .mem_force(mem_force),
        .mem_store(mem_store), .dmem_ack(dmem_ack), .halt(halt),
        .IR_Wen(a_ir), .PC_Wen(a_pc), .PSR_Wen(a_psr), .RF_Wen(a_rf), .ST_Wen(a_st),
        .EXSTtoMEM_Wen(a_ex), .dmem_req(a_req), .busy(a_busy), .timeout_err(a_terr),
        .state(a_state), .cyc_cnt(a_cyc), .inst_cnt(a_inst)
    );

    stage_sequencer #(.MEM_WAIT(3), .TIMEOUT(8), .CNT_W(8)) u_dut1 (
        .clk(clk), .resetn(rn1), .mem_inst(mem_inst), .mem_force(mem_force),
        .mem_store(mem_store), .dmem_ack(dmem_ack), .halt(halt),
        .IR_Wen(b_ir), .PC_Wen(b_pc), .PSR_Wen(b_psr), .RF_Wen(b_rf), .ST_Wen(b_st),
        .EXSTtoMEM_Wen(b_ex), .dmem_req(b_req), .busy(b_busy), .timeout_err(b_terr),
        .state(b_state), .cyc_cnt(b_cyc), .inst_cnt(b_inst)
    );

    int          sel;
    int          mw, to;
    logic [31:0] cmask;
    int          n_checks, n_err;
    logic        m_terr;
    int unsigned m_cyc, m_inst;

    logic [10:0] va, vb, ov;
    logic [31:0] oc, oi;
    logic        ot;
    assign va = {a_state, a_ir, a_pc, a_psr, a_rf, a_st, a_ex, a_req, a_busy};
    assign vb = {b_state, b_ir, b_pc, b_psr, b_rf, b_st, b_ex, b_req, b_busy};
    assign ov = (sel == 0) ? va : vb;
    assign ot = (sel == 0) ? a_terr : b_terr;
    assign oc = (sel == 0) ? a_cyc : {24'd0, b_cyc};
    assign oi = (sel == 0) ? a_inst : {24'd0, b_inst};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic rand_inputs();
        mem_inst  = 1'($urandom);
        mem_force = 1'($urandom);
        mem_store = 1'($urandom);
        dmem_ack  = 1'($urandom);
        halt      = 1'($urandom);
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the reference counters.
    task automatic cyc(input logic [2:0] s, input logic ir, input logic pc, input logic psr,
                       input logic rf, input logic stw, input logic ex, input logic req,
                       input bit abort);
        logic        bsy;
        logic [31:0] ec, ei;
        bsy = (s >= 3'd1) && (s <= 3'd4);
`ifdef STAGE_PERF_CNT_EN
        ec = m_cyc & cmask;
        ei = m_inst & cmask;
`else
        ec = 32'd0;
        ei = 32'd0;
`endif
        @(negedge clk);
        check("outputs", 32'(ov), 32'({s, ir, pc, psr, rf, stw, ex, req, bsy}));
        check("timeout_err", 32'(ot), 32'(m_terr));
        check("cyc_cnt", oc, ec);
        check("inst_cnt", oi, ei);
        if (s != 3'd0) m_cyc++;
        if (pc) m_inst++;
        if (abort) m_terr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check the immediate effect, release and see the RST cycle.
    task automatic do_reset();
        rand_inputs();
        if (sel == 0) rn0 = 1'b0; else rn1 = 1'b0;
        #1;
        check("rst_outputs", 32'(ov), 32'd0);
        check("rst_timeout_err", 32'(ot), 32'd0);
        check("rst_cyc_cnt", oc, 32'd0);
        check("rst_inst_cnt", oi, 32'd0);
        m_terr = 1'b0;
        m_cyc  = 0;
        m_inst = 0;
        @(posedge clk);
        #1;
        if (sel == 0) rn0 = 1'b1; else rn1 = 1'b1;
        rand_inputs();
        cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_halt(input int n);
        rand_inputs();
        halt = 1'b1;
        cyc(3'd1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < n; k++) begin
            rand_inputs();
            halt = 1'b1;
            cyc(3'd5, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        rand_inputs();
        halt = 1'b0;
        cyc(3'd5, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One instruction from FETCH; each access gets an ack that holds high from offset d
    // (offset 0 = MEM cycle) with random noise inside the ignored minimum-wait window.
    task automatic run_instr(input bit mi, input int nacc, input int dmin, input int dmax);
        int   d, gate, c;
        logic frc, st;
        rand_inputs();
        halt = 1'b0;
        cyc(3'd1, 1, 0, 0, 0, 0, 0, 0, 0);
        rand_inputs();
        mem_inst = mi;
        cyc(3'd2, 0, !mi, 1, !mi, 1, 1, 0, 0);
        if (!mi) return;
        for (int i = 0; i < nacc; i++) begin
            d    = $urandom_range(dmax, dmin);
            gate = (mw == 0) ? 0 : mw + 1;
            c    = (d > gate) ? d : gate;
            frc  = (i < nacc - 1);
            st   = 1'($urandom);
            for (int t = 0; ; t++) begin
                rand_inputs();
                mem_force = frc;
                mem_store = st;
                dmem_ack  = (t >= d) ? 1'b1 : ((t < gate) ? 1'($urandom) : 1'b0);
                if (t == c) begin
                    cyc((t == 0) ? 3'd3 : 3'd4, 0, !frc, 0, !st, frc, frc, 1, 0);
                    if (!frc) return;
                    break;
                end else if (t > 0 && t - 1 == to) begin
                    cyc(3'd4, 0, 1, 0, 0, 0, 0, 1, 1);
                    return;
                end else begin
                    cyc((t == 0) ? 3'd3 : 3'd4, 0, 0, 0, 0, 0, 0, 1, 0);
                end
            end
        end
    endtask

    task automatic reset_mid_wait();
        rand_inputs();
        halt = 1'b0;
        cyc(3'd1, 1, 0, 0, 0, 0, 0, 0, 0);
        rand_inputs();
        mem_inst = 1'b1;
        cyc(3'd2, 0, 0, 1, 0, 1, 1, 0, 0);
        rand_inputs();
        dmem_ack = 1'b0;
        cyc(3'd3, 0, 0, 0, 0, 0, 0, 1, 0);
        rand_inputs();
        dmem_ack = 1'b0;
        cyc(3'd4, 0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
    endtask

    task automatic random_mix(input int n, input int dmax);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 4) == 0) do_halt($urandom_range(1, 3));
            run_instr(1'($urandom), $urandom_range(1, 3), 0, dmax);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        m_terr   = 1'b0;
        m_cyc    = 0;
        m_inst   = 0;
        rn0      = 1'b0;
        rn1      = 1'b0;
        sel      = 0;
        mw       = 0;
        to       = 255;
        cmask    = 32'hFFFF_FFFF;
        rand_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Defaults: ALU stream, forced stack chain, random mix, reset mid-access.
        do_reset();
        repeat (10) run_instr(0, 1, 0, 0);
        run_instr(1, 3, 0, 0);
        random_mix(40, 3);
        reset_mid_wait();
        random_mix(5, 3);

        // MEM_WAIT=3, TIMEOUT=8, 8-bit counters.
        rn0   = 1'b0;
        sel   = 1;
        mw    = 3;
        to    = 8;
        cmask = 32'h0000_00FF;
        do_reset();
        run_instr(1, 1, 0, 0);
        run_instr(1, 2, 1000, 1000);
        run_instr(0, 1, 0, 0);
        run_instr(1, 1, 9, 9);
        run_instr(1, 1, 10, 10);
        random_mix(60, 11);
        reset_mid_wait();
        random_mix(5, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL provide parameter MEM_WAIT, default 0: minimum wait cycles in WAIT before a memory completion is accepted.
REQ-002 SHALL provide parameter TIMEOUT, default 255: maximum WAIT cycles before a forced abort (legal range MEM_WAIT < TIMEOUT <= 65535).
REQ-003 SHALL provide parameter CNT_W, default 32: width of the performance counters.
REQ-004 SHALL provide the following ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_inst  in  1  instruction in EXEC needs a MEM stage.
- mem_force  in  1  stack instruction needs another MEM access.
- mem_store  in  1  current MEM access is a write.
- dmem_ack  in  1  memory completion.
- halt  in  1  pause request, honoured at the FETCH boundary.
- IR_Wen, PC_Wen, PSR_Wen, RF_Wen, ST_Wen, EXSTtoMEM_Wen  out  1 each  stage write enables.
- dmem_req  out  1  memory access pending.
- busy  out  1  sequencer active.
- timeout_err  out  1  sticky abort flag.
- state  out  3  current state code.
- cyc_cnt, inst_cnt  out  CNT_W each  performance counters.

Function
REQ-005 SHALL use state codes RST=0, FETCH=1, EXEC=2, MEM=3, WAIT=4, HALT=5; codes 6 and 7 SHALL go to FETCH on the next cycle with all enables 0.
REQ-006 RST: all enables 0; next state FETCH unconditionally.
REQ-007 FETCH with halt=1: next HALT, all enables 0.
REQ-008 FETCH with halt=0: IR_Wen=1; next EXEC.
REQ-009 EXEC: PSR_Wen=1, ST_Wen=1, EXSTtoMEM_Wen=1.
- mem_inst=0: also RF_Wen=1 and PC_Wen=1; next FETCH.
- mem_inst=1: RF_Wen=0 and PC_Wen=0; next MEM.
REQ-010 MEM: dmem_req=1; wait counter cleared.
- MEM_WAIT=0 and dmem_ack=1: complete in this cycle (REQ-012).
- Otherwise: next WAIT.
REQ-011 WAIT: dmem_req=1; wait counter increments each cycle; width = ceil(log2(TIMEOUT+1)).
- Complete when counter >= MEM_WAIT and dmem_ack=1.
- dmem_ack while counter < MEM_WAIT is ignored.
REQ-012 Completion:
- RF_Wen = ~mem_store.
- mem_force=1: ST_Wen=1, EXSTtoMEM_Wen=1, PC_Wen=0; next MEM, starting a fresh access.
- mem_force=0: PC_Wen=1; next FETCH.
REQ-013 Timeout: in WAIT with counter == TIMEOUT and no completion:
- timeout_err set;
- RF_Wen=0, PC_Wen=1;
- next FETCH;
- any remaining mem_force accesses are abandoned.
REQ-014 timeout_err SHALL stay set until reset; it has no effect on subsequent sequencing.
REQ-015 HALT: all enables 0, dmem_req=0; next FETCH the cycle after halt=0 is sampled.
REQ-016 halt SHALL be ignored in every state except FETCH and HALT; an instruction in flight always finishes.
REQ-017 busy = 1 in FETCH, EXEC, MEM and WAIT; 0 in RST, HALT and codes 6/7.
REQ-018 All outputs SHALL be decoded from the registered state, the counters and the current inputs; there is no combinational path from dmem_ack to dmem_req.
REQ-019 state SHALL output the registered state code.

Reset
REQ-020 When resetn=0, asynchronously:
- state=RST;
- wait counter=0;
- timeout_err=0;
- cyc_cnt=0 and inst_cnt=0;
- all enables 0, dmem_req=0, busy=0.
REQ-021 Reset asserted mid-access SHALL abort immediately, with no further enable pulses.
REQ-022 After resetn rises, the first IR_Wen SHALL occur exactly 2 cycles later (RST, then FETCH).

Configuration
REQ-023 Macro STAGE_PERF_CNT_EN defined:
- cyc_cnt increments every cycle whose state is not RST;
- inst_cnt increments on every PC_Wen pulse, including timeout aborts;
- both counters wrap modulo 2^CNT_W.
REQ-024 Macro STAGE_PERF_CNT_EN undefined: cyc_cnt and inst_cnt are tied to 0, the ports remain, and no counter flops are built.

Verification
REQ-025 Defaults, mem_inst=0 stream, halt=0 -> state sequence 0,1,2,1,2...; PC_Wen every 2nd cycle; inst_cnt=10 after 20 cycles in FETCH/EXEC (macro on).
REQ-026 MEM_WAIT=3, load (mem_store=0), dmem_ack=1 from the MEM cycle onward -> WAIT lasts 4 cycles; single RF_Wen on the completion cycle; PC_Wen on the same cycle.
REQ-027 mem_force=1 for 2 accesses, then 0, with ack immediate -> states 2,3,3,3,1; EXSTtoMEM_Wen pulses in EXEC and on the first two completions; PC_Wen only on the last.
REQ-028 TIMEOUT=8, dmem_ack held 0 -> 8 WAIT cycles, then timeout_err=1, PC_Wen=1, no RF_Wen; the next instruction sequences normally with timeout_err still 1.
REQ-029 halt=1 raised during WAIT -> the access completes, then FETCH, then HALT with busy=0; halt=0 -> FETCH on the next cycle with IR_Wen=1.
REQ-030 resetn pulsed low in WAIT -> all outputs 0 asynchronously; state=0 after release; timeout_err=0; first IR_Wen 2 cycles after release.
